demux_router: RTL and testbench

//  Input-side counterpart of the output mux. Takes the decryption input byte

---
 rtl/demux_router.sv | 178 +++++++++++++++++
 tb/tb_demux_router.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_router.sv
// demux_router: steers each incoming message to one of three decryptor
// channels. The channel is taken from 'select' on the first word of a message
// and held until the terminator word; messages opened with select==3 are
// swallowed and flagged with a one-cycle error pulse.
module demux_router #(
  parameter int                 D_WIDTH   = 8,
  parameter logic [D_WIDTH-1:0] TERM      = 8'hFA,
  parameter int                 CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           select,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  output logic [D_WIDTH-1:0]   data0_o,
  output logic                 valid0_o,
  output logic [D_WIDTH-1:0]   data1_o,
  output logic                 valid1_o,
  output logic [D_WIDTH-1:0]   data2_o,
  output logic                 valid2_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [D_WIDTH-1:0]   data0_q, data0_d;
  logic [D_WIDTH-1:0]   data1_q, data1_d;
  logic [D_WIDTH-1:0]   data2_q, data2_d;
  logic                 valid0_q, valid0_d;
  logic                 valid1_q, valid1_d;
  logic                 valid2_q, valid2_d;

  logic                 route_en;
  logic [1:0]           route_ch;
  logic                 is_term;

  // Word counter stops at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c) begin
      return c;
    end
    return c + CNT_ONE;
  endfunction

  assign is_term = (data_i == TERM);

  // Next-state decode: FSM transitions, counter update and channel steering.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    count_d  = count_q;
    err_d    = 1'b0;
    route_en = 1'b0;
    route_ch = sel_q;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    valid2_d = 1'b0;
    data0_d  = data0_q;
    data1_d  = data1_q;
    data2_d  = data2_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          // First word of a message: counter restarts regardless of outcome.
          count_d = CNT_ONE;
          if (select == 2'd3) begin
            err_d   = 1'b1;
            state_d = is_term ? IDLE : DROP;
          end else begin
            sel_d    = select;
            route_en = 1'b1;
            route_ch = select;
            state_d  = is_term ? IDLE : ROUTE;
          end
        end
      end
      ROUTE: begin
        // select is ignored here; the channel stays locked in sel_q.
        if (valid_i) begin
          route_en = 1'b1;
          route_ch = sel_q;
          count_d  = sat_inc(count_q);
          if (is_term) begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (valid_i) begin
          count_d = sat_inc(count_q);
          if (is_term) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Only the selected channel sees a pulse and a new word; others hold.
    if (route_en) begin
      case (route_ch)
        2'd0: begin
          valid0_d = 1'b1;
          data0_d  = data_i;
        end
        2'd1: begin
          valid1_d = 1'b1;
          data1_d  = data_i;
        end
        2'd2: begin
          valid2_d = 1'b1;
          data2_d  = data_i;
        end
        default: begin
          valid0_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any message in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      count_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      count_q  <= count_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
    end
  end

  assign data0_o  = data0_q;
  assign data1_o  = data1_q;
  assign data2_o  = data2_q;
  assign valid0_o = valid0_q;
  assign valid1_o = valid1_q;
  assign valid2_o = valid2_q;
  assign busy_o   = busy_q;
  assign count_o  = count_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_demux_router.sv
// Testbench for demux_router: scenario tasks push expected (channel, word)
// pairs into a scoreboard queue; a negedge monitor pops and compares every
// valid pulse. Counter width is reduced so saturation is reachable quickly.
module tb_demux_router;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [1:0]    select;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic [DW-1:0] data0_o, data1_o, data2_o;
  logic          valid0_o, valid1_o, valid2_o;
  logic          busy_o;
  logic [CW-1:0] count_o;
  logic          err_o;

  int tests;
  int fails;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  demux_router #(
    .D_WIDTH  (DW),
    .TERM     (8'hFA),
    .CNT_WIDTH(CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .select  (select),
    .data_i  (data_i),
    .valid_i (valid_i),
    .data0_o (data0_o),
    .valid0_o(valid0_o),
    .data1_o (data1_o),
    .valid1_o(valid1_o),
    .data2_o (data2_o),
    .valid2_o(valid2_o),
    .busy_o  (busy_o),
    .count_o (count_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every valid pulse must match the head of the scoreboard.
  int          mon_nv;
  logic [1:0]  mon_ch;
  logic [DW-1:0] mon_data;
  exp_t        mon_e;
  always @(negedge clk) begin
    mon_nv = int'(valid0_o) + int'(valid1_o) + int'(valid2_o);
    if (mon_nv != 0) begin
      mon_ch   = valid0_o ? 2'd0 : (valid1_o ? 2'd1 : 2'd2);
      mon_data = valid0_o ? data0_o : (valid1_o ? data1_o : data2_o);
      tests++;
      if (mon_nv > 1) begin
        fails++;
        $display("FAIL onehot: %0d valids high at once, required 1", mon_nv);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: ch=%0d data=%h, required no output", mon_ch, mon_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_ch !== mon_e.ch || mon_data !== mon_e.data) begin
          fails++;
          $display("FAIL route: got ch=%0d data=%h, required ch=%0d data=%h",
                   mon_ch, mon_data, mon_e.ch, mon_e.data);
        end
      end
    end
  end

  // Drive one word; returns 1 time unit after the edge that captured it.
  task automatic send(input logic [1:0] sel, input logic [DW-1:0] d);
    valid_i = 1'b1;
    select  = sel;
    data_i  = d;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    select  = 2'd0;
    data_i  = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing: %0d words not delivered, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    valid_i = 1'b0;
    select  = 2'd0;
    data_i  = '0;
    #12;
    tests++;
    if ({valid0_o, valid1_o, valid2_o, busy_o, err_o} !== 5'b0 || count_o !== '0 ||
        data0_o !== '0 || data1_o !== '0 || data2_o !== '0) begin
      fails++;
      $display("FAIL reset_state: v=%b%b%b busy=%b err=%b cnt=%0d d=%h/%h/%h, required all 0",
               valid0_o, valid1_o, valid2_o, busy_o, err_o, count_o, data0_o, data1_o, data2_o);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_route_ch1();
    exp_q.push_back('{2'd1, 8'h41});
    exp_q.push_back('{2'd1, 8'h42});
    exp_q.push_back('{2'd1, 8'hFA});
    send(2'd1, 8'h41);
    tests++;
    if (busy_o !== 1'b1 || count_o !== 4'd1) begin
      fails++;
      $display("FAIL ch1_first: busy=%b cnt=%0d, required busy=1 cnt=1", busy_o, count_o);
    end
    send(2'd1, 8'h42);
    send(2'd1, 8'hFA);
    tests++;
    if (busy_o !== 1'b0 || count_o !== 4'd3) begin
      fails++;
      $display("FAIL ch1_end: busy=%b cnt=%0d, required busy=0 cnt=3", busy_o, count_o);
    end
    drain("ch1");
  endtask

  task automatic test_select_locked();
    exp_q.push_back('{2'd2, 8'h10});
    exp_q.push_back('{2'd2, 8'h11});
    exp_q.push_back('{2'd2, 8'hFA});
    send(2'd2, 8'h10);
    idle_cycles(2);
    tests++;
    if (busy_o !== 1'b1 || count_o !== 4'd1) begin
      fails++;
      $display("FAIL lock_gap: busy=%b cnt=%0d, required busy=1 cnt=1", busy_o, count_o);
    end
    send(2'd0, 8'h11);
    send(2'd0, 8'hFA);
    tests++;
    if (count_o !== 4'd3 || data2_o !== 8'hFA || data0_o !== 8'h00) begin
      fails++;
      $display("FAIL lock_end: cnt=%0d d2=%h d0=%h, required cnt=3 d2=fa d0=00",
               count_o, data2_o, data0_o);
    end
    drain("lock");
  endtask

  task automatic test_drop();
    send(2'd3, 8'h55);
    tests++;
    if (err_o !== 1'b1 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL drop_err: err=%b busy=%b, required err=1 busy=1", err_o, busy_o);
    end
    send(2'd1, 8'h66);
    tests++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL drop_errpulse: err=%b, required 0", err_o);
    end
    send(2'd0, 8'hFA);
    tests++;
    if (busy_o !== 1'b0 || count_o !== 4'd3 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL drop_end: busy=%b cnt=%0d err=%b, required busy=0 cnt=3 err=0",
               busy_o, count_o, err_o);
    end
    drain("drop");
  endtask

  task automatic test_single_word();
    exp_q.push_back('{2'd0, 8'hFA});
    send(2'd0, 8'hFA);
    tests++;
    if (busy_o !== 1'b0 || count_o !== 4'd1 || data0_o !== 8'hFA) begin
      fails++;
      $display("FAIL single: busy=%b cnt=%0d d0=%h, required busy=0 cnt=1 d0=fa",
               busy_o, count_o, data0_o);
    end
    drain("single");
  endtask

  task automatic test_reset_mid();
    exp_q.push_back('{2'd0, 8'h01});
    exp_q.push_back('{2'd0, 8'h02});
    send(2'd0, 8'h01);
    send(2'd0, 8'h02);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (busy_o !== 1'b0 || count_o !== '0 || valid0_o !== 1'b0) begin
      fails++;
      $display("FAIL rstmid: busy=%b cnt=%0d v0=%b, required 0 0 0", busy_o, count_o, valid0_o);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back('{2'd1, 8'h03});
    exp_q.push_back('{2'd1, 8'hFA});
    send(2'd1, 8'h03);
    send(2'd1, 8'hFA);
    tests++;
    if (count_o !== 4'd2 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_after: cnt=%0d busy=%b, required cnt=2 busy=0", count_o, busy_o);
    end
    drain("rstmid");
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{2'd1, 8'h01});
    exp_q.push_back('{2'd1, 8'hFA});
    exp_q.push_back('{2'd0, 8'h02});
    exp_q.push_back('{2'd0, 8'hFA});
    send(2'd1, 8'h01);
    send(2'd1, 8'hFA);
    send(2'd0, 8'h02);
    tests++;
    if (busy_o !== 1'b1 || count_o !== 4'd1) begin
      fails++;
      $display("FAIL b2b_mid: busy=%b cnt=%0d, required busy=1 cnt=1", busy_o, count_o);
    end
    send(2'd0, 8'hFA);
    tests++;
    if (busy_o !== 1'b0 || count_o !== 4'd2) begin
      fails++;
      $display("FAIL b2b_end: busy=%b cnt=%0d, required busy=0 cnt=2", busy_o, count_o);
    end
    drain("b2b");
  endtask

  task automatic test_saturation();
    send(2'd3, 8'h00);
    for (int i = 0; i < 19; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 8'hF9)));
    end
    tests++;
    if (count_o !== 4'd15 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL sat_hold: cnt=%0d busy=%b, required cnt=15 busy=1", count_o, busy_o);
    end
    send(2'd0, 8'hFA);
    tests++;
    if (count_o !== 4'd15 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL sat_end: cnt=%0d busy=%b, required cnt=15 busy=0", count_o, busy_o);
    end
    idle_cycles(2);
    exp_q.push_back('{2'd2, 8'hFA});
    send(2'd2, 8'hFA);
    tests++;
    if (count_o !== 4'd1) begin
      fails++;
      $display("FAIL sat_restart: cnt=%0d, required 1", count_o);
    end
    drain("sat");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_route_ch1();
    test_select_locked();
    test_drop();
    test_single_word();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    idle_cycles(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
